// File: rtl/buraq_pkg.sv
// Shared types and constants for the instruction fetch/align path.
package buraq_pkg;

  typedef logic [15:0] halfword_t;
  typedef logic [31:0] word_t;

  // Low two bits of a halfword that mark the start of a 32-bit instruction.
  localparam logic [1:0] C_OPCODE_FULL = 2'b11;

  // A parcel is compressed unless its low two bits select the 32-bit encoding.
  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != C_OPCODE_FULL;
  endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Small circular buffer of fetched words.
// Exposes the head word and the low half of the entry behind it, so that a
// 32-bit instruction straddling two words can be stitched combinationally.
module fetch_word_fifo
  import buraq_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  word_t            data_i,
  input  logic             pop_i,
  output word_t            head_o,
  output halfword_t        next_lo_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] count_q;
  word_t            mem_q [BUF_DEPTH];
  word_t            next_word;

  // Pointer and occupancy bookkeeping; a clear empties the buffer at once.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_ONE;
      if (pop_i)  rd_q <= rd_q + PTR_ONE;
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Word storage carries no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_q] <= data_i;
  end

  assign next_word = mem_q[rd_q + PTR_ONE];
  assign head_o    = mem_q[rd_q];
  assign next_lo_o = next_word[15:0];
  assign count_o   = count_q;

  // The issue rule reserves a slot for every outstanding request.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || clr_i)
    !(push_i && count_q == FULL_CNT));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset || clr_i)
    !(pop_i && count_q == '0));

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch/align controller: issues word fetches, buffers the returned words and
// presents a halfword-aligned stream of 16-bit and 32-bit instruction parcels.
// Redirects clear the buffer and drop every response still in flight.
module fetch_align_ctrl
  import buraq_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_lsb,
  output logic [15:0] instr_msb,
  output logic        instr_c,
  output logic [31:0] instr_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(BUF_DEPTH);
  localparam logic [SUM_W-1:0] MAXO_L  = SUM_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  logic [31:0]      fetch_addr_q;
  logic             hw_off_q;
  logic [31:0]      instr_pc_q;
  logic [CNT_W-1:0] outst_q;
  logic [CNT_W-1:0] drop_q;

  word_t            head;
  halfword_t        next_lo;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  logic [SUM_W-1:0] reserved;
  logic             req_fire;
  logic [CNT_W-1:0] outst_nxt;
  halfword_t        cur_hw;
  halfword_t        nxt_hw;
  logic             cur_c;
  logic             have2;
  logic             parcel_ok;
  logic             consume;

  fetch_word_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (flush),
    .push_i    (push),
    .data_i    (imem_rsp_data),
    .pop_i     (pop),
    .head_o    (head),
    .next_lo_o (next_lo),
    .count_o   (count)
  );

  // Every buffered word and every outstanding request owns one buffer slot.
  assign reserved       = SUM_W'(outst_q) + SUM_W'(count);
  assign imem_req_valid = !reset && !flush && (reserved < DEPTH_L) &&
                          (SUM_W'(outst_q) < MAXO_L);
  assign imem_req_addr  = fetch_addr_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign outst_nxt      = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

  // Responses owed to a redirected stream are discarded; flush drops all.
  assign push = imem_rsp_valid && (drop_q == '0) && !flush;

  // Halfword window: hw_off selects which half of the head word is current,
  // the following halfword may live in the next buffer entry.
  assign cur_hw = hw_off_q ? head[31:16] : head[15:0];
  assign nxt_hw = hw_off_q ? next_lo : head[31:16];
  assign cur_c  = is_compressed(cur_hw);
  // Two halfwords available: one word at offset 0, two words at offset 1.
  assign have2  = hw_off_q ? (count >= TWO_C) : (count >= ONE_C);

  assign parcel_ok   = (count != '0) && (cur_c || have2);
  assign instr_valid = parcel_ok;
  assign instr_c     = parcel_ok && cur_c;
  assign instr_lsb   = parcel_ok ? cur_hw : 16'h0000;
  assign instr_msb   = (parcel_ok && !cur_c) ? nxt_hw : 16'h0000;
  assign instr_pc    = instr_pc_q;

  // A C parcel pops only when it was the upper half; a 32-bit parcel always
  // finishes off the head word, keeping hw_off unchanged.
  assign consume = parcel_ok && instr_ready && !flush;
  assign pop     = consume && (cur_c ? hw_off_q : 1'b1);

  // Fetch address, halfword offset, parcel PC and in-flight accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q <= BOOT_ADDR & ~32'h3;
      hw_off_q     <= BOOT_ADDR[1];
      instr_pc_q   <= BOOT_ADDR & ~32'h1;
      outst_q      <= '0;
      drop_q       <= '0;
    end else begin
      outst_q <= outst_nxt;
      if (flush) begin
        drop_q       <= outst_nxt;
        fetch_addr_q <= flush_pc & ~32'h3;
        hw_off_q     <= flush_pc[1];
        instr_pc_q   <= flush_pc & ~32'h1;
      end else begin
        if (imem_rsp_valid && (drop_q != '0)) drop_q <= drop_q - ONE_C;
        if (req_fire) fetch_addr_q <= fetch_addr_q + 32'd4;
        if (consume) begin
          instr_pc_q <= instr_pc_q + (cur_c ? 32'd2 : 32'd4);
          if (cur_c) hw_off_q <= !hw_off_q;
        end
      end
    end
  end

  // A response with nothing outstanding means the memory side lost sync.
  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && outst_q == '0));

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Bench for fetch_align_ctrl: in-order memory with programmable latency, a
// PC-driven instruction-stream model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_fetch_align_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_lsb;
  logic [15:0] instr_msb;
  logic        instr_c;
  logic [31:0] instr_pc;

  int n_pass  = 0;
  int n_total = 0;
  int mem_lat = 2;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  fetch_align_ctrl #(.BOOT_ADDR(BOOT), .BUF_DEPTH(2), .MAX_OUTST(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_lsb      (instr_lsb),
    .instr_msb      (instr_msb),
    .instr_c        (instr_c),
    .instr_pc       (instr_pc)
  );

  // Unmapped words hold two compressed halfwords tagged with their address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:2], 2'b10, wa[15:2], 2'b00};
  endfunction

  function automatic logic [15:0] mem_half(input logic [31:0] p);
    logic [31:0] w;
    w = mem_word(p);
    return p[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // In-order memory: a request accepted at an edge answers mem_lat edges later.
  initial begin
    logic [31:0] qa[$];
    int          qd[$];
    int          cyc;
    cyc = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        qa.delete();
        qd.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        qa.push_back(imem_req_addr);
        qd.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() > 0 && qd[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(qa[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_DEAD;
      end
    end
  end

  // Stream model: the parcel at PC p is defined by memory alone.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [15:0] m_lsb;
    logic [15:0] m_msb;
    logic        m_c;
    logic        hold_prev;
    logic        fire;
    @(posedge clk);
    exp_pc    = BOOT & ~32'h1;
    exp_fetch = BOOT & ~32'h3;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      m_lsb = mem_half(exp_pc);
      m_c   = (m_lsb[1:0] != 2'b11);
      m_msb = m_c ? 16'h0 : mem_half(exp_pc + 32'd2);
      chk("pc", instr_pc, exp_pc);
      if (reset || flush) chk("req_blocked", 32'(imem_req_valid), 32'h0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
      if (instr_valid) begin
        chk("lsb", 32'(instr_lsb), 32'(m_lsb));
        chk("msb", 32'(instr_msb), 32'(m_msb));
        chk("c", 32'(instr_c), 32'(m_c));
      end
      if (hold_prev) chk("hold_valid", 32'(instr_valid), 32'h1);
      fire      = instr_valid && instr_ready;
      hold_prev = instr_valid && !instr_ready && !flush && !reset;
      if (reset) begin
        exp_pc    = BOOT & ~32'h1;
        exp_fetch = BOOT & ~32'h3;
      end else if (flush) begin
        exp_pc    = flush_pc & ~32'h1;
        exp_fetch = flush_pc & ~32'h3;
      end else begin
        if (fire) exp_pc = exp_pc + (m_c ? 32'd2 : 32'd4);
        if (imem_req_valid && imem_req_ready) exp_fetch = exp_fetch + 32'd4;
      end
    end
  end

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!instr_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!instr_valid) begin
      n_total++;
      $display("FAIL %s: instr_valid got 0 expected 1 within 50 cycles", name);
    end
  endtask

  task automatic do_flush(input logic [31:0] pc);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    flush_pc = pc;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic consume_one();
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
  endtask

  task automatic chk_parcel(input string name, input logic [15:0] lsb, input logic [15:0] msb,
                            input logic c, input logic [31:0] pc);
    chk({name, "_lsb"}, 32'(instr_lsb), 32'(lsb));
    chk({name, "_msb"}, 32'(instr_msb), 32'(msb));
    chk({name, "_c"}, 32'(instr_c), 32'(c));
    chk({name, "_pc"}, instr_pc, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no finish, expected one");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    flush_pc       = 32'h0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem[32'h080] = 32'h0013_0093;
    mem[32'h000] = 32'h4505_0505;
    mem[32'h200] = 32'h0093_0001;
    mem[32'h204] = 32'hABCD_0013;
    mem[32'h100] = 32'hC0DE_BEEF;
    mem[32'h300] = 32'hFFFF_FFFF;
    mem[32'h304] = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) mem[32'h800 + 32'(i) * 4] = $urandom();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk_parcel("rst", 16'h0, 16'h0, 1'b0, 32'h80);
    @(posedge clk);
    #1 reset = 1'b0;

    // Boot fetch of a 32-bit addi
    @(negedge clk);
    chk("boot_req_valid", 32'(imem_req_valid), 32'h1);
    chk("boot_req_addr", imem_req_addr, 32'h80);
    wait_valid("boot");
    chk_parcel("boot", 16'h0093, 16'h0013, 1'b0, 32'h80);

    // Consumer stalls: parcel held, issue stops when the buffer is reserved
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_v", 32'(instr_valid), 32'h1);
      chk_parcel("hold", 16'h0093, 16'h0013, 1'b0, 32'h80);
    end
    chk("hold_req_stopped", 32'(imem_req_valid), 32'h0);

    // Two compressed parcels from one word
    do_flush(32'h0);
    wait_valid("c2_a");
    chk_parcel("c2_a", 16'h0505, 16'h0, 1'b1, 32'h0);
    consume_one();
    wait_valid("c2_b");
    chk_parcel("c2_b", 16'h4505, 16'h0, 1'b1, 32'h2);
    consume_one();
    wait_valid("c2_next");
    chk_parcel("c2_next", 16'h0004, 16'h0, 1'b1, 32'h4);

    // 32-bit parcel straddling a word boundary
    do_flush(32'h200);
    wait_valid("str_a");
    chk_parcel("str_a", 16'h0001, 16'h0, 1'b1, 32'h200);
    consume_one();
    wait_valid("str_b");
    chk_parcel("str_b", 16'h0093, 16'h0013, 1'b0, 32'h202);
    consume_one();
    wait_valid("str_c");
    chk_parcel("str_c", 16'hABCD, 16'h0, 1'b1, 32'h206);

    // Redirect with two requests in flight
    mem_lat = 5;
    do_flush(32'h300);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("two_outst_req_valid", 32'(imem_req_valid), 32'h0);
    do_flush(32'h102);
    @(negedge clk);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    chk("redir_instr_valid", 32'(instr_valid), 32'h0);
    wait_valid("redir");
    chk_parcel("redir", 16'hC0DE, 16'h0, 1'b1, 32'h102);

    // Reset mid-stream with a response pending
    do_flush(32'h400);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_instr_valid", 32'(instr_valid), 32'h0);
    chk("mrst_req_valid", 32'(imem_req_valid), 32'h0);
    chk_parcel("mrst", 16'h0, 16'h0, 1'b0, 32'h80);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_lat = 2;
    @(negedge clk);
    chk("mrst_req_valid2", 32'(imem_req_valid), 32'h1);
    chk("mrst_req_addr", imem_req_addr, 32'h80);
    wait_valid("mrst_boot");
    chk_parcel("mrst_boot", 16'h0093, 16'h0013, 1'b0, 32'h80);

    // Mixed-width stream with random back-pressure, latency and redirects
    do_flush(32'h800);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_lat        = int'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) begin
        flush    = 1'b1;
        flush_pc = 32'h800 + 32'($urandom_range(0, 127)) * 2;
      end else begin
        flush = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    flush          = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    repeat (8) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
